spi_cmd_ctrl: RTL and testbench

- Command dispatcher between the SPI slave front end (8-bit command frames, 16-bit data frames) and the register, FIFO and RAM resources.
- Decodes each command into a persistent access mode and applies subsequent data frames to the selected target.
- Prefetches read data so a valid word is held on tx_dat before the master opens a read frame.

---
 rtl/spi_cmd_ctrl_pkg.sv | 44 ++++
 rtl/spi_cmd_ctrl_decode.sv | 34 +++
 rtl/spi_cmd_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_ctrl_pkg.sv
// rtl/spi_cmd_ctrl_pkg.sv - command codes, access modes and read FSM states
package spi_cmd_ctrl_pkg;

  localparam int CMD_W = 8;

  localparam logic [CMD_W-1:0] CMD_REG1      = 8'h01;
  localparam logic [CMD_W-1:0] CMD_REG2      = 8'h02;
  localparam logic [CMD_W-1:0] CMD_REG3      = 8'h03;
  localparam logic [CMD_W-1:0] CMD_FIFO_DATA = 8'h04;
  localparam logic [CMD_W-1:0] CMD_WADDR     = 8'h05;
  localparam logic [CMD_W-1:0] CMD_RADDR     = 8'h06;
  localparam logic [CMD_W-1:0] CMD_RAM_DATA  = 8'h07;
  localparam logic [CMD_W-1:0] CMD_RD_FLAG   = 8'h80;
  localparam logic [CMD_W-1:0] CMD_FIFO_RD   = 8'h84;
  localparam logic [CMD_W-1:0] CMD_RAM_RD    = 8'h87;
  localparam logic [CMD_W-1:0] CMD_STATUS    = 8'hFF;

  typedef enum logic [3:0] {
    MODE_NONE,
    MODE_REG1,
    MODE_REG2,
    MODE_REG3,
    MODE_FIFO_WR,
    MODE_WADDR,
    MODE_RADDR,
    MODE_RAM_WR,
    MODE_SUM,
    MODE_FIFO_RD,
    MODE_RAM_RD,
    MODE_STATUS
  } mode_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_RAM_ISSUE,
    RD_RAM_CAP,
    RD_READY
  } rd_state_e;

  function automatic logic mode_is_read(mode_e m);
    return m inside {MODE_SUM, MODE_FIFO_RD, MODE_RAM_RD, MODE_STATUS};
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_decode.sv
// rtl/spi_cmd_ctrl_decode.sv - combinational command byte to access mode lookup
module spi_cmd_decode
  import spi_cmd_ctrl_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW-1:0] cmd_i,
  output mode_e         mode_o,
  output logic          rd_o
);

  always_comb begin
    mode_o = MODE_NONE;
    case (cmd_i)
      CW'(CMD_REG1):      mode_o = MODE_REG1;
      CW'(CMD_REG2):      mode_o = MODE_REG2;
      CW'(CMD_REG3):      mode_o = MODE_REG3;
      CW'(CMD_FIFO_DATA): mode_o = MODE_FIFO_WR;
      CW'(CMD_WADDR):     mode_o = MODE_WADDR;
      CW'(CMD_RADDR):     mode_o = MODE_RADDR;
      CW'(CMD_RAM_DATA):  mode_o = MODE_RAM_WR;
      CW'(CMD_RD_FLAG):   mode_o = MODE_SUM;
      CW'(CMD_FIFO_RD):   mode_o = MODE_FIFO_RD;
      CW'(CMD_RAM_RD):    mode_o = MODE_RAM_RD;
      CW'(CMD_STATUS):    mode_o = MODE_STATUS;
      default:            mode_o = MODE_NONE;
    endcase
  end

  // Unknown codes carry the read flag too, but they map to NONE and must not
  // enable the read path.
  assign rd_o = cmd_i[CW-1] & mode_is_read(mode_o);

endmodule

// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - SPI command dispatcher for register, FIFO and RAM targets
module spi_cmd_ctrl
  import spi_cmd_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 8,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_vld_i,
  input  logic [CW-1:0] cmd_i,
  input  logic          wdat_vld_i,
  input  logic [DW-1:0] wdat_i,
  input  logic          rd_done_i,
  output logic [DW-1:0] tx_dat_o,
  output logic          tx_vld_o,
  output logic          fifo_wr_en_o,
  output logic [DW-1:0] fifo_wdat_o,
  input  logic          fifo_full_i,
  output logic          fifo_rd_en_o,
  input  logic [DW-1:0] fifo_rdat_i,
  input  logic          fifo_empty_i,
  output logic          ram_we_o,
  output logic          ram_re_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdat_o,
  input  logic [DW-1:0] ram_rdat_i,
  output logic [1:0]    err_o
);

  mode_e     dec_mode;
  logic      dec_rd;

  mode_e     mode_q;
  logic      rd_dir_q;
  rd_state_e state_q;
  logic [DW-1:0] reg1_q, reg2_q, reg3_q;
  logic [AW-1:0] waddr_q, raddr_q;
  logic [DW-1:0] tx_dat_q;
  logic          tx_vld_q;
  logic          fifo_wr_en_q, fifo_rd_en_q;
  logic [DW-1:0] fifo_wdat_q;
  logic          ram_we_q, ram_re_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdat_q;
  logic [1:0]    err_q;

  logic [DW-1:0] sum_d;
  logic [DW-1:0] status_d;
  logic [AW-1:0] raddr_inc_d;

  spi_cmd_decode #(.CW(CW)) u_decode (
    .cmd_i  (cmd_i),
    .mode_o (dec_mode),
    .rd_o   (dec_rd)
  );

  assign sum_d       = reg1_q + reg2_q + reg3_q;
  assign status_d    = {{(DW-2){1'b0}}, err_q};
  assign raddr_inc_d = raddr_q + AW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q       <= MODE_NONE;
      rd_dir_q     <= 1'b0;
      state_q      <= RD_IDLE;
      reg1_q       <= '0;
      reg2_q       <= '0;
      reg3_q       <= '0;
      waddr_q      <= '0;
      raddr_q      <= '0;
      tx_dat_q     <= '0;
      tx_vld_q     <= 1'b0;
      fifo_wr_en_q <= 1'b0;
      fifo_wdat_q  <= '0;
      fifo_rd_en_q <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdat_q   <= '0;
      err_q        <= '0;
    end else begin
      fifo_wr_en_q <= 1'b0;
      fifo_rd_en_q <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;

      // A command always wins: coincident data/rd_done pulses are dropped and
      // any RAM prefetch in flight is abandoned without touching raddr.
      if (cmd_vld_i) begin
        mode_q   <= dec_mode;
        rd_dir_q <= dec_rd;
        tx_vld_q <= 1'b0;
        tx_dat_q <= '0;
        if (dec_mode == MODE_RAM_RD) begin
          state_q    <= RD_RAM_ISSUE;
          ram_re_q   <= 1'b1;
          ram_addr_q <= raddr_q;
        end else begin
          state_q <= RD_IDLE;
        end
      end else if (!rd_dir_q) begin
        if (wdat_vld_i) begin
          case (mode_q)
            MODE_REG1:  reg1_q <= wdat_i;
            MODE_REG2:  reg2_q <= wdat_i;
            MODE_REG3:  reg3_q <= wdat_i;
            MODE_FIFO_WR: begin
              if (fifo_full_i) begin
                err_q[1] <= 1'b1;
              end else begin
                fifo_wr_en_q <= 1'b1;
                fifo_wdat_q  <= wdat_i;
              end
            end
            MODE_WADDR: waddr_q <= wdat_i[AW-1:0];
            MODE_RADDR: raddr_q <= wdat_i[AW-1:0];
            MODE_RAM_WR: begin
              ram_we_q   <= 1'b1;
              ram_addr_q <= waddr_q;
              ram_wdat_q <= wdat_i;
              waddr_q    <= waddr_q + AW'(1);
            end
            default: ;
          endcase
        end
      end else if (mode_q == MODE_FIFO_RD) begin
        // FWFT head is mirrored continuously; a pop only follows a finished frame.
        tx_dat_q <= fifo_empty_i ? '0 : fifo_rdat_i;
        tx_vld_q <= !fifo_empty_i;
        if (rd_done_i) begin
          if (fifo_empty_i) begin
            err_q[0] <= 1'b1;
          end else begin
            fifo_rd_en_q <= 1'b1;
          end
        end
      end else begin
        case (state_q)
          RD_IDLE: begin
            tx_dat_q <= (mode_q == MODE_STATUS) ? status_d : sum_d;
            tx_vld_q <= 1'b1;
            state_q  <= RD_READY;
          end
          RD_RAM_ISSUE: state_q <= RD_RAM_CAP;
          RD_RAM_CAP: begin
            tx_dat_q <= ram_rdat_i;
            tx_vld_q <= 1'b1;
            state_q  <= RD_READY;
          end
          RD_READY: begin
            if (rd_done_i) begin
              if (mode_q == MODE_RAM_RD) begin
                raddr_q    <= raddr_inc_d;
                ram_re_q   <= 1'b1;
                ram_addr_q <= raddr_inc_d;
                tx_vld_q   <= 1'b0;
                state_q    <= RD_RAM_ISSUE;
              end else if (mode_q == MODE_STATUS) begin
                err_q <= '0;
              end
            end
          end
          default: state_q <= RD_IDLE;
        endcase
      end
    end
  end

  assign tx_dat_o     = tx_dat_q;
  assign tx_vld_o     = tx_vld_q;
  assign fifo_wr_en_o = fifo_wr_en_q;
  assign fifo_wdat_o  = fifo_wdat_q;
  assign fifo_rd_en_o = fifo_rd_en_q;
  assign ram_we_o     = ram_we_q;
  assign ram_re_o     = ram_re_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdat_o   = ram_wdat_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb/tb_spi_cmd_ctrl.sv - directed self-checking bench for spi_cmd_ctrl
module tb_spi_cmd_ctrl;
  import spi_cmd_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int AW = 8;
  localparam int FDEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_vld;
  logic [CW-1:0] cmd;
  logic          wdat_vld;
  logic [DW-1:0] wdat;
  logic          rd_done;
  logic [DW-1:0] tx_dat;
  logic          tx_vld;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wdat;
  logic          fifo_full;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rdat;
  logic          fifo_empty;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdat;
  logic [DW-1:0] ram_rdat;
  logic [1:0]    err;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fmem [FDEPTH];
  int            fhead = 0;
  int            fcount = 0;
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  logic [DW-1:0] rmem [256];
  logic [AW-1:0] we_addr_log [$];
  logic [DW-1:0] we_data_log [$];

  always #5 clk = ~clk;

  spi_cmd_ctrl #(.DW(DW), .CW(CW), .AW(AW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_vld_i    (cmd_vld),
    .cmd_i        (cmd),
    .wdat_vld_i   (wdat_vld),
    .wdat_i       (wdat),
    .rd_done_i    (rd_done),
    .tx_dat_o     (tx_dat),
    .tx_vld_o     (tx_vld),
    .fifo_wr_en_o (fifo_wr_en),
    .fifo_wdat_o  (fifo_wdat),
    .fifo_full_i  (fifo_full),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_rdat_i  (fifo_rdat),
    .fifo_empty_i (fifo_empty),
    .ram_we_o     (ram_we),
    .ram_re_o     (ram_re),
    .ram_addr_o   (ram_addr),
    .ram_wdat_o   (ram_wdat),
    .ram_rdat_i   (ram_rdat),
    .err_o        (err)
  );

  // FWFT FIFO and 1-cycle-latency RAM models
  assign fifo_empty = (fcount == 0);
  assign fifo_full  = (fcount == FDEPTH);
  assign fifo_rdat  = fmem[fhead];

  always @(posedge clk) begin
    if (fifo_wr_en && fcount < FDEPTH) fmem[(fhead + fcount) % FDEPTH] <= fifo_wdat;
    if (fifo_rd_en && fcount > 0) fhead <= (fhead + 1) % FDEPTH;
    fcount <= fcount + ((fifo_wr_en && fcount < FDEPTH) ? 1 : 0)
                     - ((fifo_rd_en && fcount > 0) ? 1 : 0);
    if (fifo_wr_en) wr_cnt <= wr_cnt + 1;
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (ram_we) begin
      rmem[ram_addr] <= ram_wdat;
      we_addr_log.push_back(ram_addr);
      we_data_log.push_back(ram_wdat);
    end
    if (ram_re) ram_rdat <= rmem[ram_addr];
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [CW-1:0] c);
    @(negedge clk);
    cmd_vld = 1'b1;
    cmd = c;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic send_wdat(input logic [DW-1:0] d);
    @(negedge clk);
    wdat_vld = 1'b1;
    wdat = d;
    @(negedge clk);
    wdat_vld = 1'b0;
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL reset_tx_vld: got %b exp 0", tx_vld); end
    checks++; if (tx_dat !== 16'h0000) begin errors++; $display("FAIL reset_tx_dat: got %h exp 0000", tx_dat); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b exp 00", err); end
    checks++; if ({ram_we, ram_re, fifo_wr_en, fifo_rd_en} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b exp 0000", {ram_we, ram_re, fifo_wr_en, fifo_rd_en});
    end
    checks++; if (dut.state_q !== RD_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dut.state_q, RD_IDLE); end
  endtask

  task automatic test_regs_sum();
    send_cmd(8'h01); send_wdat(16'h1234);
    send_cmd(8'h02); send_wdat(16'h0F0F);
    send_cmd(8'h03); send_wdat(16'hF000);
    send_cmd(8'h80);
    checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL sum_vld_clear: got %b exp 0", tx_vld); end
    tick(1);
    checks++; if (tx_vld !== 1'b1) begin errors++; $display("FAIL sum_vld: got %b exp 1", tx_vld); end
    checks++; if (tx_dat !== 16'h1143) begin errors++; $display("FAIL sum_dat: got %h exp 1143", tx_dat); end
    pulse_rd();
    tick(1);
    checks++; if (tx_dat !== 16'h1143 || tx_vld !== 1'b1) begin
      errors++; $display("FAIL sum_after_rd: got %h/%b exp 1143/1", tx_dat, tx_vld);
    end
  endtask

  task automatic test_fifo();
    int wr0;
    int rd0;
    wr0 = wr_cnt;
    send_cmd(8'h04);
    for (int i = 1; i <= 10; i++) send_wdat(DW'(i));
    tick(2);
    checks++; if (wr_cnt - wr0 !== 10) begin errors++; $display("FAIL fifo_push_cnt: got %0d exp 10", wr_cnt - wr0); end
    rd0 = rd_cnt;
    send_cmd(8'h84);
    tick(2);
    for (int i = 1; i <= 10; i++) begin
      checks++; if (tx_vld !== 1'b1 || tx_dat !== DW'(i)) begin
        errors++; $display("FAIL fifo_word%0d: got %h/%b exp %h/1", i, tx_dat, tx_vld, DW'(i));
      end
      pulse_rd();
      tick(3);
    end
    checks++; if (rd_cnt - rd0 !== 10) begin errors++; $display("FAIL fifo_pop_cnt: got %0d exp 10", rd_cnt - rd0); end
    checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL fifo_drained_vld: got %b exp 0", tx_vld); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL fifo_err: got %b exp 00", err); end
  endtask

  task automatic test_ram();
    we_addr_log.delete(); we_data_log.delete();
    send_cmd(8'h05); send_wdat(16'h0003);
    send_cmd(8'h07); send_wdat(16'hAAAA); send_wdat(16'hBBBB);
    tick(2);
    checks++; if (we_addr_log.size() !== 2) begin errors++; $display("FAIL ram_we_cnt: got %0d exp 2", we_addr_log.size()); end
    checks++; if (we_addr_log[0] !== 8'h03 || we_data_log[0] !== 16'hAAAA) begin
      errors++; $display("FAIL ram_we0: got %h:%h exp 03:aaaa", we_addr_log[0], we_data_log[0]);
    end
    checks++; if (we_addr_log[1] !== 8'h04 || we_data_log[1] !== 16'hBBBB) begin
      errors++; $display("FAIL ram_we1: got %h:%h exp 04:bbbb", we_addr_log[1], we_data_log[1]);
    end
    send_cmd(8'h06); send_wdat(16'h0003);
    send_cmd(8'h87);
    checks++; if (ram_re !== 1'b1 || ram_addr !== 8'h03 || tx_vld !== 1'b0) begin
      errors++; $display("FAIL ram_issue: got re=%b addr=%h vld=%b exp 1/03/0", ram_re, ram_addr, tx_vld);
    end
    tick(1);
    checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL ram_cap_vld: got %b exp 0", tx_vld); end
    tick(1);
    checks++; if (tx_vld !== 1'b1 || tx_dat !== 16'hAAAA) begin
      errors++; $display("FAIL ram_rd0: got %h/%b exp aaaa/1", tx_dat, tx_vld);
    end
    pulse_rd();
    checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL ram_reprefetch_vld: got %b exp 0", tx_vld); end
    tick(2);
    checks++; if (tx_vld !== 1'b1 || tx_dat !== 16'hBBBB) begin
      errors++; $display("FAIL ram_rd1: got %h/%b exp bbbb/1", tx_dat, tx_vld);
    end
  endtask

  task automatic test_underflow_status();
    int rd0;
    rd0 = rd_cnt;
    send_cmd(8'h84);
    tick(2);
    checks++; if (tx_vld !== 1'b0 || tx_dat !== 16'h0000) begin
      errors++; $display("FAIL udf_tx: got %h/%b exp 0000/0", tx_dat, tx_vld);
    end
    pulse_rd();
    tick(2);
    checks++; if (rd_cnt !== rd0) begin errors++; $display("FAIL udf_no_pop: got %0d exp %0d", rd_cnt, rd0); end
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL udf_err: got %b exp 01", err); end
    send_cmd(8'hFF);
    tick(1);
    checks++; if (tx_vld !== 1'b1 || tx_dat !== 16'h0001) begin
      errors++; $display("FAIL status_dat: got %h/%b exp 0001/1", tx_dat, tx_vld);
    end
    pulse_rd();
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL status_clear: got %b exp 00", err); end
  endtask

  task automatic test_overflow_wrap();
    int wr0;
    wr0 = wr_cnt;
    send_cmd(8'h04);
    for (int i = 0; i < FDEPTH; i++) send_wdat(DW'(16'h0100 + i));
    tick(2);
    checks++; if (err[1] !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b exp 0", err[1]); end
    send_wdat(16'hDEAD);
    tick(2);
    checks++; if (wr_cnt - wr0 !== FDEPTH) begin errors++; $display("FAIL ovf_push_cnt: got %0d exp %0d", wr_cnt - wr0, FDEPTH); end
    checks++; if (err !== 2'b10) begin errors++; $display("FAIL ovf_err: got %b exp 10", err); end
    we_addr_log.delete(); we_data_log.delete();
    send_cmd(8'h05); send_wdat(16'h00FF);
    send_cmd(8'h07); send_wdat(16'h1111); send_wdat(16'h2222);
    tick(2);
    checks++; if (we_addr_log.size() !== 2) begin errors++; $display("FAIL wrap_cnt: got %0d exp 2", we_addr_log.size()); end
    checks++; if (we_addr_log[0] !== 8'hFF || we_addr_log[1] !== 8'h00) begin
      errors++; $display("FAIL wrap_addr: got %h,%h exp ff,00", we_addr_log[0], we_addr_log[1]);
    end
  endtask

  task automatic test_cmd_wins();
    we_addr_log.delete(); we_data_log.delete();
    @(negedge clk);
    cmd_vld = 1'b1; cmd = 8'h80;
    wdat_vld = 1'b1; wdat = 16'h5555;
    @(negedge clk);
    cmd_vld = 1'b0; wdat_vld = 1'b0;
    tick(2);
    checks++; if (we_addr_log.size() !== 0) begin errors++; $display("FAIL cmd_wins_we: got %0d exp 0", we_addr_log.size()); end
    checks++; if (tx_dat !== 16'h1143) begin errors++; $display("FAIL cmd_wins_sum: got %h exp 1143", tx_dat); end
  endtask

  task automatic test_rst_mid();
    send_cmd(8'h87);
    tick(1);
    checks++; if (dut.state_q !== RD_RAM_CAP) begin errors++; $display("FAIL rst_pre_state: got %0d exp %0d", dut.state_q, RD_RAM_CAP); end
    rst = 1'b1;
    #1;
    checks++; if (tx_vld !== 1'b0 || ram_re !== 1'b0) begin
      errors++; $display("FAIL rst_mid_out: got vld=%b re=%b exp 0/0", tx_vld, ram_re);
    end
    checks++; if (dut.state_q !== RD_IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d exp %0d", dut.state_q, RD_IDLE); end
    @(negedge clk);
    rst = 1'b0;
    send_cmd(8'h80);
    tick(1);
    checks++; if (tx_vld !== 1'b1 || tx_dat !== 16'h0000) begin
      errors++; $display("FAIL rst_regs_sum: got %h/%b exp 0000/1", tx_dat, tx_vld);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < FDEPTH; i++) fmem[i] = '0;
    for (int i = 0; i < 256; i++) rmem[i] = '0;
    ram_rdat = '0;
    rst = 1'b1;
    cmd_vld = 1'b0; cmd = '0;
    wdat_vld = 1'b0; wdat = '0;
    rd_done = 1'b0;
    test_reset();
    test_regs_sum();
    test_fifo();
    test_ram();
    test_underflow_status();
    test_overflow_wrap();
    test_cmd_wins();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
